aes_round_iter: RTL and testbench

- Iterative AES-128 encryption core for the first nine rounds, one round per clock.
- Accepts a plaintext/key pair, performs the initial AddRoundKey and rounds 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey, with on-the-fly key expansion.
- Hands the round-9 state, round-9 key and round number 10 to the downstream last-round stage, which does SubBytes, ShiftRows and the round-10 key XOR.
- Valid/ready handshakes on both sides.

---
 rtl/aes_round_iter_if.sv | 24 ++
 rtl/aes_round_iter.sv | 197 +++++++++++++++++++
 tb/tb_aes_round_iter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_iter_if.sv
// Handshake and data bundle for the iterative AES-128 round core.
// The master side is the block producer and consumer; the slave side is the core.
interface aes_round_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, out_key, out_round, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, out_key, out_round, busy
    );
endinterface

// File: rtl/aes_round_iter.sv
// Iterative AES-128 core covering the initial key add and rounds 1..9,
// one round per clock with on-the-fly key expansion. The round-9 state and
// round-9 key are handed to a downstream last-round stage with round tag 10.
module aes_round_iter (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_iter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        sub_byte = SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        sub_bytes = {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Row r rotates left by r columns; byte i sits at row i%4, column i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        shift_rows = {s[127:120], s[87:80],   s[47:40],   s[7:0],
                      s[95:88],   s[55:48],   s[15:8],    s[103:96],
                      s[63:56],   s[23:16],   s[111:104], s[71:64],
                      s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        mix_columns = {mix_column(s[127:96]), mix_column(s[95:64]),
                       mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Next round key from the current one; r selects the round constant.
    function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] t, w4, w5, w6, w7;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(r), 24'h000000};
        w4 = k[127:96] ^ t;
        w5 = k[95:64]  ^ w4;
        w6 = k[63:32]  ^ w5;
        w7 = k[31:0]   ^ w6;
        expand = {w4, w5, w6, w7};
    endfunction

    fsm_t         fsm_r, fsm_nxt_s;
    logic [3:0]   rnd_r, rnd_nxt_s;
    logic [127:0] blk_r, blk_nxt_s;
    logic [127:0] key_r, key_nxt_s;
    logic [127:0] out_data_r, out_data_nxt_s;
    logic [127:0] out_key_r, out_key_nxt_s;
    logic         out_valid_r;
    logic [3:0]   out_round_r;
    logic         busy_r;
    logic         in_ready_s;
    logic [127:0] nk_s;
    logic [127:0] round_out_s;

    assign nk_s        = expand(key_r, rnd_r);
    assign round_out_s = mix_columns(shift_rows(sub_bytes(blk_r))) ^ nk_s;

    // Next-state, datapath update and input-ready decode.
    always_comb begin
        fsm_nxt_s      = fsm_r;
        rnd_nxt_s      = rnd_r;
        blk_nxt_s      = blk_r;
        key_nxt_s      = key_r;
        out_data_nxt_s = out_data_r;
        out_key_nxt_s  = out_key_r;
        in_ready_s     = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    blk_nxt_s = bus.in_data ^ bus.in_key;
                    key_nxt_s = bus.in_key;
                    rnd_nxt_s = 4'd1;
                    fsm_nxt_s = ST_RUN;
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                blk_nxt_s = round_out_s;
                key_nxt_s = nk_s;
                if (rnd_r == 4'd9) begin
                    // Counter parks at 9; the result is latched for the consumer.
                    fsm_nxt_s      = ST_DONE;
                    out_data_nxt_s = round_out_s;
                    out_key_nxt_s  = nk_s;
                end else begin
                    rnd_nxt_s = rnd_r + 4'd1;
                end
            end
            ST_DONE: begin
                // Accepting in the handoff cycle gives back-to-back blocks.
                in_ready_s = bus.out_ready;
                if (bus.out_ready && bus.in_valid) begin
                    blk_nxt_s = bus.in_data ^ bus.in_key;
                    key_nxt_s = bus.in_key;
                    rnd_nxt_s = 4'd1;
                    fsm_nxt_s = ST_RUN;
                end else if (bus.out_ready) begin
                    fsm_nxt_s = ST_IDLE;
                end else begin
                    fsm_nxt_s = ST_DONE;
                end
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            rnd_r       <= 4'd0;
            blk_r       <= 128'h0;
            key_r       <= 128'h0;
            out_data_r  <= 128'h0;
            out_key_r   <= 128'h0;
            out_valid_r <= 1'b0;
            out_round_r <= 4'd0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            rnd_r       <= rnd_nxt_s;
            blk_r       <= blk_nxt_s;
            key_r       <= key_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_key_r   <= out_key_nxt_s;
            out_valid_r <= (fsm_nxt_s == ST_DONE);
            out_round_r <= (fsm_nxt_s == ST_DONE) ? 4'd10 : 4'd0;
            busy_r      <= (fsm_nxt_s != ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_key   = out_key_r;
    assign bus.out_round = out_round_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: known-answer vectors chained through a
// behavioural last-round stage, plus backpressure, back-to-back and reset cases.
module tb_aes_round_iter;

    logic clk;
    logic rst_n;
    aes_round_iter_if bus ();

    aes_round_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Downstream last-round model; S-box built from GF inverse plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < 253; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] last_round(input logic [127:0] st, input logic [127:0] k9);
        logic [31:0]  t, w4, w5, w6, w7;
        logic [127:0] r;
        int           src;
        t  = {m_sbox(k9[23:16]), m_sbox(k9[15:8]), m_sbox(k9[7:0]), m_sbox(k9[31:24])} ^ 32'h36000000;
        w4 = k9[127:96] ^ t;
        w5 = k9[95:64]  ^ w4;
        w6 = k9[63:32]  ^ w5;
        w7 = k9[31:0]   ^ w6;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            r[127 - 8 * i -: 8] = m_sbox(st[127 - 8 * src -: 8]);
        end
        return r ^ {w4, w5, w6, w7};
    endfunction

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] exp_st;
        logic [127:0] exp_k9;
        logic [127:0] exp_ct;
        bit           has_mid;
    } vec_t;

    vec_t vecs [5];

    task automatic do_accept(input logic [127:0] d, input logic [127:0] k, input string tag);
        bus.in_data  = d;
        bus.in_key   = k;
        bus.in_valid = 1'b1;
        chk_b({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_b({tag, "_busy_run"}, bus.busy, 1'b1);
        chk_b({tag, "_in_ready_run"}, bus.in_ready, 1'b0);
    endtask

    task automatic wait_valid(input bit scramble, output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            if (scramble) begin
                bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.in_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input int i, input string tag);
        int cyc;
        bus.out_ready = 1'b1;
        do_accept(vecs[i].pt, vecs[i].key, tag);
        wait_valid(1'b1, cyc);
        chk_i({tag, "_latency"}, cyc, 9);
        chk({tag, "_out_round"}, 128'(bus.out_round), 128'(4'd10));
        if (vecs[i].has_mid) begin
            chk({tag, "_out_data"}, bus.out_data, vecs[i].exp_st);
            chk({tag, "_out_key"}, bus.out_key, vecs[i].exp_k9);
        end
        chk({tag, "_ciphertext"}, last_round(bus.out_data, bus.out_key), vecs[i].exp_ct);
        @(posedge clk);
        #1;
        chk_b({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
        chk({tag, "_out_round_after"}, 128'(bus.out_round), 128'(4'd0));
        chk_b({tag, "_idle_ready"}, bus.in_ready, 1'b1);
        chk_b({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic [127:0] held_d, held_k;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'heb40f21e592e38848ba113e71bc342d2, 128'hac7766f319fadc2128d12941575c006e,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1};
        vecs[1] = '{128'h0, 128'h0, 128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h0, 128'h0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        vecs[3] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h0, 128'h0, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b0};
        vecs[4] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h0, 128'h0, 128'hf5d3d58503b9699de785895a96fdbaaf, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 128'h0;
        bus.in_key    = 128'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_b("rst_out_valid", bus.out_valid, 1'b0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_round", 128'(bus.out_round), 128'(4'd0));
        chk("rst_out_data", bus.out_data, 128'h0);
        chk("rst_out_key", bus.out_key, 128'h0);
        rst_n = 1'b1;

        // Known-answer vectors with input scrambling while the block runs.
        for (int i = 0; i < 5; i++) begin
            run_vec(i, $sformatf("vec%0d", i));
        end

        // Backpressure: stall the consumer for 20 cycles and poke in_valid.
        bus.out_ready = 1'b0;
        do_accept(vecs[0].pt, vecs[0].key, "bp");
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            bus.in_valid = cyc[0];
            bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid !== 1'b1) chk_b("bp_in_ready_run", bus.in_ready, 1'b0);
        end
        chk_i("bp_latency", cyc, 9);
        chk("bp_out_data", bus.out_data, vecs[0].exp_st);
        chk("bp_out_key", bus.out_key, vecs[0].exp_k9);
        held_d = bus.out_data;
        held_k = bus.out_key;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = k[0];
            bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            chk_b("bp_stall_valid", bus.out_valid, 1'b1);
            chk("bp_stall_data", bus.out_data, held_d);
            chk("bp_stall_key", bus.out_key, held_k);
            chk_b("bp_stall_in_ready", bus.in_ready, 1'b0);
            chk("bp_stall_round", 128'(bus.out_round), 128'(4'd10));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_b("bp_release_valid", bus.out_valid, 1'b0);
        chk_b("bp_release_busy", bus.busy, 1'b0);
        chk("bp_release_data_hold", bus.out_data, held_d);
        @(posedge clk);
        #1;
        chk_b("bp_single_transfer", bus.out_valid, 1'b0);

        // Back-to-back: second block waits on in_valid and is taken in the DONE cycle.
        bus.out_ready = 1'b1;
        do_accept(vecs[0].pt, vecs[0].key, "b2b_a");
        bus.in_data  = vecs[3].pt;
        bus.in_key   = vecs[3].key;
        bus.in_valid = 1'b1;
        wait_valid(1'b0, cyc);
        chk_i("b2b_a_latency", cyc, 9);
        chk("b2b_a_data", bus.out_data, vecs[0].exp_st);
        chk("b2b_a_key", bus.out_key, vecs[0].exp_k9);
        chk_b("b2b_done_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_b("b2b_b_accept_busy", bus.busy, 1'b1);
        chk_b("b2b_b_accept_valid", bus.out_valid, 1'b0);
        wait_valid(1'b0, cyc);
        chk_i("b2b_spacing", cyc + 1, 10);
        chk("b2b_b_ciphertext", last_round(bus.out_data, bus.out_key), vecs[3].exp_ct);
        @(posedge clk);
        #1;
        chk_b("b2b_idle_busy", bus.busy, 1'b0);

        // Asynchronous reset in the middle of a run.
        do_accept(vecs[0].pt, vecs[0].key, "rst_mid");
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_b("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk_b("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_out_data", bus.out_data, 128'h0);
        chk("rst_mid_out_key", bus.out_key, 128'h0);
        chk("rst_mid_out_round", 128'(bus.out_round), 128'(4'd0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_b("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk_b("rst_mid_no_resume", bus.busy, 1'b0);
        run_vec(0, "rst_mid_rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
